// File: rtl/tone_pkg.sv
// tone_pkg: shared definitions for the music-box tone path.
//   NUM_NOTES / NOTE_IDX_W : eight notes C4..C5, 3-bit index
//   F_*                    : note frequencies in Hz
//   note_period()          : clk_hz / f(idx), the clock-divider count for a note
//   tone_state_e           : tone_detector FSM states
package tone_pkg;

    localparam int NUM_NOTES  = 8;
    localparam int NOTE_IDX_W = 3;

    localparam int unsigned F_C4 = 262;
    localparam int unsigned F_D4 = 294;
    localparam int unsigned F_E4 = 330;
    localparam int unsigned F_F4 = 349;
    localparam int unsigned F_G4 = 392;
    localparam int unsigned F_A4 = 440;
    localparam int unsigned F_B4 = 494;
    localparam int unsigned F_C5 = 523;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS,
        ST_SCAN,
        ST_REPORT
    } tone_state_e;

    // Only ever called with constant arguments, so the division folds away.
    function automatic int unsigned note_period(input int unsigned clk_hz,
                                                input int unsigned idx);
        int unsigned f;
        case (idx)
            0:       f = F_C4;
            1:       f = F_D4;
            2:       f = F_E4;
            3:       f = F_F4;
            4:       f = F_G4;
            5:       f = F_A4;
            6:       f = F_B4;
            default: f = F_C5;
        endcase
        return clk_hz / f;
    endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// tone_sync_edge: 2-FF synchronizer followed by a rising-edge detector.
//   clk, rst_n : system clock, async active-low reset
//   i_async    : asynchronous level input (tone, button, ...)
//   o_rise     : one-cycle pulse, high in the third cycle after i_async rises
module tone_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a real pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/tone_detector.sv
// tone_detector: measures the period of an asynchronous square-wave tone and
// classifies it as one of the eight notes C4..C5.
//   clk, rst_n : system clock, async active-low reset
//   tone_in    : asynchronous square-wave tone
//   note_idx   : last matched note (0=C4 .. 7=C5)
//   note_valid : current tone matches note_idx
//   note_stb   : one-cycle pulse per reported match
//   period     : last captured period in clk cycles
// Optional build macro TONE_DET_CONFIRM_EN: a hit is only published when the
// previous scan hit the same index.
module tone_detector
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned TOL_SHIFT = 5,
    parameter int unsigned TIMEOUT   = CLK_HZ / 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tone_in,
    output logic [NOTE_IDX_W-1:0] note_idx,
    output logic                  note_valid,
    output logic                  note_stb,
    output logic [CNT_W-1:0]      period
);

    localparam logic [CNT_W-1:0]      TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]      TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [NOTE_IDX_W-1:0] LAST_IDX   = NOTE_IDX_W'(NUM_NOTES - 1);

    tone_state_e           r_state, w_state_nxt;
    logic                  w_rise;
    logic [CNT_W-1:0]      r_cnt, r_cap, r_period, w_ref;
    logic [CNT_W-1:0]      w_ref_tab [NUM_NOTES];
    logic [CNT_W:0]        w_diff, w_abs, w_tol;
    logic                  w_hit, w_timeout, w_capture, w_report, w_drop;
    logic                  w_final_hit;
    logic [NOTE_IDX_W-1:0] r_scan_idx, r_found_idx, w_final_idx, r_note_idx;
    logic                  r_found, r_note_valid, r_note_stb;
`ifdef TONE_DET_CONFIRM_EN
    logic                  r_pend_vld;
    logic [NOTE_IDX_W-1:0] r_pend_idx;
`endif

    tone_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (tone_in),
        .o_rise  (w_rise)
    );

    // Note table as constants; one entry is compared per SCAN cycle.
    for (genvar g = 0; g < NUM_NOTES; g++) begin : g_ref
        assign w_ref_tab[g] = CNT_W'(note_period(CLK_HZ, g));
    end
    assign w_ref = w_ref_tab[r_scan_idx];

    // One extra bit keeps the sign of period - ref.
    assign w_diff = {1'b0, r_cap} - {1'b0, w_ref};
    assign w_abs  = w_diff[CNT_W] ? -w_diff : w_diff;
    assign w_tol  = {1'b0, w_ref >> TOL_SHIFT};
    assign w_hit  = (w_abs <= w_tol);

    // The last SCAN cycle folds its own comparison into the recorded result.
    assign w_final_hit = r_found | w_hit;
    assign w_final_idx = r_found ? r_found_idx : r_scan_idx;

    // Fires on the edge that takes cnt to TIMEOUT; a rising edge wins.
    assign w_timeout = (r_cnt == TIMEOUT_M1) && !w_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_report    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) w_state_nxt = ST_MEAS;
            end
            ST_MEAS: begin
                if (w_rise) begin
                    w_state_nxt = ST_SCAN;
                    w_capture   = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_drop      = 1'b1;
                end
            end
            ST_SCAN: begin
                if (w_rise) begin
                    w_capture = 1'b1;
                end else if (r_scan_idx == LAST_IDX) begin
                    w_state_nxt = ST_REPORT;
                    w_report    = 1'b1;
                end
            end
            ST_REPORT: begin
                if (w_rise) begin
                    w_state_nxt = ST_SCAN;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = ST_MEAS;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_cap        <= '0;
            r_scan_idx   <= '0;
            r_found      <= 1'b0;
            r_found_idx  <= '0;
            r_note_idx   <= '0;
            r_note_valid <= 1'b0;
            r_note_stb   <= 1'b0;
            r_period     <= '0;
`ifdef TONE_DET_CONFIRM_EN
            r_pend_vld   <= 1'b0;
            r_pend_idx   <= '0;
`endif
        end else begin
            r_note_stb <= 1'b0;

            // Free-running period counter, saturating so silence is visible.
            if (w_rise)                  r_cnt <= '0;
            else if (r_cnt != TIMEOUT_C) r_cnt <= r_cnt + CNT_W'(1);

            // A capture also restarts any scan in flight.
            if (w_capture) begin
                r_cap      <= r_cnt + CNT_W'(1);
                r_scan_idx <= '0;
                r_found    <= 1'b0;
            end else if (r_state == ST_SCAN) begin
                r_scan_idx <= r_scan_idx + NOTE_IDX_W'(1);
                if (w_hit && !r_found) begin
                    r_found     <= 1'b1;
                    r_found_idx <= r_scan_idx;
                end
            end

            if (w_drop) begin
                r_note_valid <= 1'b0;
`ifdef TONE_DET_CONFIRM_EN
                r_pend_vld   <= 1'b0;
`endif
            end

            if (w_report) begin
                r_period <= r_cap;
`ifdef TONE_DET_CONFIRM_EN
                if (w_final_hit) begin
                    r_pend_vld <= 1'b1;
                    r_pend_idx <= w_final_idx;
                    if (r_pend_vld && (r_pend_idx == w_final_idx)) begin
                        r_note_idx   <= w_final_idx;
                        r_note_valid <= 1'b1;
                        r_note_stb   <= 1'b1;
                    end else begin
                        r_note_valid <= 1'b0;
                    end
                end else begin
                    r_note_valid <= 1'b0;
                    r_pend_vld   <= 1'b0;
                end
`else
                if (w_final_hit) begin
                    r_note_idx   <= w_final_idx;
                    r_note_valid <= 1'b1;
                    r_note_stb   <= 1'b1;
                end else begin
                    r_note_valid <= 1'b0;
                end
`endif
            end
        end
    end

    assign note_idx   = r_note_idx;
    assign note_valid = r_note_valid;
    assign note_stb   = r_note_stb;
    assign period     = r_period;

endmodule
